// File: rtl/i2c_seq_pkg.sv
// Shared constants for the I2C transfer sequencer: widths, bit counts and FSM encodings.
package i2c_seq_pkg;

  localparam int CNT_W         = 8;
  localparam int BITS_PER_BYTE = 9;
  localparam logic [3:0] ACK_BIT_IDX = 4'(BITS_PER_BYTE - 1);

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOW     = 3'd1;
  localparam logic [2:0] ST_STRETCH = 3'd2;
  localparam logic [2:0] ST_HIGH    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/counter.sv
// Loadable up-counter; load takes priority over enable.
module counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         asyn_rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst)    cnt_q <= '0;
    else if (load_i) cnt_q <= load_val_i;
    else if (en_i)   cnt_q <= cnt_q + W'(1);
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/i2c_xfer_sequencer.sv
// SCL phase timing plus bit/byte counting for an I2C master byte transfer.
// state   | meaning
// IDLE    | waiting for start
// LOW     | driving SCL low for P cycles
// STRETCH | SCL released, waiting for the slave to let it rise
// HIGH    | SCL released for P cycles
// DONE    | one-cycle completion pulse
module i2c_xfer_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int CNT_W = i2c_seq_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             asyn_rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] prescale_i,
  input  logic [CNT_W-1:0] byte_len_i,
  input  logic             scl_in_i,
  output logic             scl_oe_o,
  output logic             shift_en_o,
  output logic             bit_tick_o,
  output logic             ack_slot_o,
  output logic             byte_done_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] p_q, p_d, n_q, n_d;
  logic [CNT_W-1:0] tmr, tmr_next, byte_cnt;
  logic             tmr_load, tmr_en, byte_inc, byte_clr, phase_last, byte_last, next_last;
  logic             scl_oe_q, shift_en_q, bit_tick_q, ack_slot_q, byte_done_q, busy_q, done_q;

  counter #(.W(CNT_W)) u_phase_tmr (
    .clk        (clk),
    .asyn_rst   (asyn_rst),
    .load_i     (tmr_load),
    .load_val_i ('0),
    .en_i       (tmr_en),
    .cnt_o      (tmr)
  );

  counter #(.W(CNT_W)) u_byte_cnt (
    .clk        (clk),
    .asyn_rst   (asyn_rst),
    .load_i     (byte_clr),
    .load_val_i ('0),
    .en_i       (byte_inc),
    .cnt_o      (byte_cnt)
  );

  assign phase_last = (tmr == p_q - ONE);
  assign byte_last  = ({1'b0, byte_cnt} + {1'b0, ONE}) == {1'b0, n_q};
  assign tmr_en     = (state_q == ST_LOW) || (state_q == ST_HIGH);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    p_d       = p_q;
    n_d       = n_q;
    byte_inc  = 1'b0;
    byte_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          p_d       = (prescale_i == '0) ? ONE : prescale_i;
          n_d       = byte_len_i;
          bit_cnt_d = '0;
          byte_clr  = 1'b1;
          state_d   = (byte_len_i == '0) ? ST_DONE : ST_LOW;
        end
      end
      ST_LOW: begin
        if (phase_last) state_d = scl_in_i ? ST_HIGH : ST_STRETCH;
      end
      ST_STRETCH: begin
        if (scl_in_i) state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (phase_last) begin
          if (bit_cnt_q == ACK_BIT_IDX) begin
            byte_inc  = 1'b1;
            bit_cnt_d = '0;
            state_d   = byte_last ? ST_DONE : ST_LOW;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            state_d   = ST_LOW;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_i) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      p_d       = p_q;
      n_d       = n_q;
      byte_inc  = 1'b0;
      byte_clr  = 1'b1;
    end
  end

  // Outputs are registered, so strobes are decoded from what the next cycle will be.
  assign tmr_load  = (state_d != state_q) || abort_i;
  assign tmr_next  = tmr_load ? '0 : tmr + ONE;
  assign next_last = (tmr_next == p_d - ONE);

  always_ff @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      p_q         <= '0;
      n_q         <= '0;
      scl_oe_q    <= 1'b0;
      shift_en_q  <= 1'b0;
      bit_tick_q  <= 1'b0;
      ack_slot_q  <= 1'b0;
      byte_done_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      p_q         <= p_d;
      n_q         <= n_d;
      scl_oe_q    <= (state_d == ST_LOW);
      shift_en_q  <= (state_d == ST_LOW) && next_last && (bit_cnt_d < ACK_BIT_IDX);
      bit_tick_q  <= (state_d == ST_HIGH) && (state_q != ST_HIGH);
      ack_slot_q  <= ((state_d == ST_LOW) || (state_d == ST_STRETCH) || (state_d == ST_HIGH))
                     && (bit_cnt_d == ACK_BIT_IDX);
      byte_done_q <= (state_d == ST_HIGH) && next_last && (bit_cnt_d == ACK_BIT_IDX);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
    end
  end

  assign scl_oe_o    = scl_oe_q;
  assign shift_en_o  = shift_en_q;
  assign bit_tick_o  = bit_tick_q;
  assign ack_slot_o  = ack_slot_q;
  assign byte_done_o = byte_done_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// Bench for i2c_xfer_sequencer: table of transfers with a strobe-timing scoreboard, plus corner sequences.
module tb_i2c_xfer_sequencer;

  typedef struct {
    int pre;
    int blen;
    int st_bit;
    int st_len;
    int exp_done;
  } vec_t;

  logic       clk = 1'b0;
  logic       asyn_rst;
  logic       start_i, abort_i, scl_in_i;
  logic [7:0] prescale_i, byte_len_i;
  logic       scl_oe_o, shift_en_o, bit_tick_o, ack_slot_o, byte_done_o, busy_o, done_o;

  int n_chk  = 0;
  int n_pass = 0;
  vec_t vecs[6];

  i2c_xfer_sequencer dut (
    .clk         (clk),
    .asyn_rst    (asyn_rst),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .prescale_i  (prescale_i),
    .byte_len_i  (byte_len_i),
    .scl_in_i    (scl_in_i),
    .scl_oe_o    (scl_oe_o),
    .shift_en_o  (shift_en_o),
    .bit_tick_o  (bit_tick_o),
    .ack_slot_o  (ack_slot_o),
    .byte_done_o (byte_done_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", nm, act, req);
  endtask

  function automatic int outs_all();
    return int'({scl_oe_o, shift_en_o, bit_tick_o, ack_slot_o, byte_done_o, busy_o, done_o});
  endfunction

  // Expected strobe cycles (relative to the start cycle) come from the SCL timing formulas.
  task automatic run_vec(input vec_t v, input string tag);
    int pe, c0, lim, done_rel, done_n, busy_bad, oe_n, ack_n, o;
    int qs[$];
    int qt[$];
    int qb[$];
    pe = (v.pre == 0) ? 1 : v.pre;
    for (int g = 0; g < 9 * v.blen; g++) begin
      o = (v.st_bit >= 0 && g >= v.st_bit) ? v.st_len : 0;
      if (g % 9 != 8) qs.push_back(pe * (2 * g + 1) + ((v.st_bit >= 0 && g > v.st_bit) ? v.st_len : 0));
      qt.push_back(1 + pe * (2 * g + 1) + o);
      if (g % 9 == 8) qb.push_back(2 * pe * (g + 1) + o);
    end
    c0 = (v.st_bit >= 0) ? pe * (2 * v.st_bit + 1) : -100;
    lim = v.exp_done + 4;
    done_rel = -1; done_n = 0; busy_bad = 0; oe_n = 0; ack_n = 0;
    @(posedge clk); #1;
    prescale_i = 8'(v.pre);
    byte_len_i = 8'(v.blen);
    start_i = 1'b1;
    for (int rel = 0; rel <= lim; rel++) begin
      if (rel == 1) start_i = 1'b0;
      if (rel == 20 && lim > 40) begin start_i = 1'b1; prescale_i = 8'd7; byte_len_i = 8'd9; end
      if (rel == 21 && lim > 40) start_i = 1'b0;
      scl_in_i = !(rel >= c0 && rel < c0 + v.st_len);
      @(negedge clk);
      if (shift_en_o) begin
        if (qs.size() == 0) chk({tag, " shift_en_extra"}, rel, -1);
        else chk({tag, " shift_en_cycle"}, rel, qs.pop_front());
      end
      if (bit_tick_o) begin
        if (qt.size() == 0) chk({tag, " bit_tick_extra"}, rel, -1);
        else chk({tag, " bit_tick_cycle"}, rel, qt.pop_front());
      end
      if (byte_done_o) begin
        if (qb.size() == 0) chk({tag, " byte_done_extra"}, rel, -1);
        else chk({tag, " byte_done_cycle"}, rel, qb.pop_front());
      end
      if (done_o) begin done_n++; done_rel = rel; end
      if (rel >= 1 && rel <= v.exp_done && !busy_o) busy_bad++;
      oe_n += int'(scl_oe_o);
      ack_n += int'(ack_slot_o);
      @(posedge clk); #1;
    end
    chk({tag, " done_cycle"}, done_rel, v.exp_done);
    chk({tag, " done_count"}, done_n, 1);
    chk({tag, " busy_gaps"}, busy_bad, 0);
    chk({tag, " busy_after"}, int'(busy_o), 0);
    chk({tag, " scl_oe_cycles"}, oe_n, 9 * v.blen * pe);
    chk({tag, " ack_slot_cycles"}, ack_n, 2 * pe * v.blen);
    chk({tag, " shift_en_missing"}, qs.size(), 0);
    chk({tag, " bit_tick_missing"}, qt.size(), 0);
    chk({tag, " byte_done_missing"}, qb.size(), 0);
  endtask

  initial begin
    vec_t rv;
    int dn, dr, oe, bd;
    vecs[0] = '{4,   1,   -1, 0,  73};
    vecs[1] = '{0,   2,   -1, 0,  37};
    vecs[2] = '{3,   1,    2, 10, 65};
    vecs[3] = '{2,   3,   -1, 0,  109};
    vecs[4] = '{255, 1,   -1, 0,  4591};
    vecs[5] = '{1,   255, -1, 0,  4591};

    asyn_rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; scl_in_i = 1'b1;
    prescale_i = 8'd0; byte_len_i = 8'd0;
    #12;
    chk("reset_outputs", outs_all(), 0);
    asyn_rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Zero-length transfer: completes without touching SCL.
    @(posedge clk); #1;
    prescale_i = 8'd4; byte_len_i = 8'd0; start_i = 1'b1;
    dn = 0; dr = -1; oe = 0;
    for (int rel = 0; rel <= 5; rel++) begin
      if (rel == 1) start_i = 1'b0;
      @(negedge clk);
      if (done_o) begin dn++; if (dr < 0) dr = rel; end
      oe += int'(scl_oe_o);
      @(posedge clk); #1;
    end
    chk("len0_done_count", dn, 1);
    chk("len0_done_within_2", int'(dr >= 1 && dr <= 2), 1);
    chk("len0_scl_oe", oe, 0);

    // Abort in HIGH of bit 5 of byte index 2 (P=2, N=3): global bit 23 HIGH starts at cycle 95.
    @(posedge clk); #1;
    prescale_i = 8'd2; byte_len_i = 8'd3; start_i = 1'b1;
    dn = 0; oe = 0; bd = 0;
    for (int rel = 0; rel <= 130; rel++) begin
      if (rel == 1) start_i = 1'b0;
      abort_i = (rel == 95);
      @(negedge clk);
      if (rel == 95) chk("abort_at_bit_tick", int'(bit_tick_o), 1);
      if (rel == 96) begin
        chk("abort_busy_next", int'(busy_o), 0);
        chk("abort_scl_oe_next", int'(scl_oe_o), 0);
      end
      bd += int'(byte_done_o);
      dn += int'(done_o);
      if (rel > 96) oe += int'(scl_oe_o);
      @(posedge clk); #1;
    end
    chk("abort_byte_done_count", bd, 2);
    chk("abort_no_done", dn, 0);
    chk("abort_scl_idle", oe, 0);
    rv = '{1, 1, -1, 0, 19};
    run_vec(rv, "restart_after_abort");

    // Asynchronous reset in the middle of a LOW phase.
    @(posedge clk); #1;
    prescale_i = 8'd4; byte_len_i = 8'd1; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_scl_oe", int'(scl_oe_o), 1);
    #2 asyn_rst = 1'b1;
    #1 chk("async_reset_outputs", outs_all(), 0);
    @(negedge clk);
    asyn_rst = 1'b0;
    run_vec(vecs[0], "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
